lcd_ctrl: RTL

Hardware HD44780 character-LCD controller sitting directly downstream of the LSU's LCD output port. It replaces software bit-banging: after reset it runs the mandatory power-up/init sequence on its own, then accepts one byte per handshake (command or data) and drives the LCD pins with correct setup, enable-pulse, hold and execution-wait timing. The bus is write-only; the busy flag is never read, and all waits are timer-based.

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_if.sv | 10 +
 rtl/lcd_timer.sv | 27 ++
 rtl/lcd_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    LOAD,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // 8-bit/2-line/5x8, display on, clear, entry mode increment
  localparam logic [7:0] LCD_INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Only instruction-register clear/home need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Write-only byte handshake between the LSU LCD port and the controller.
interface lcd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter; holds at zero and flags it so a state lasts exactly N cycles when loaded with N-1.
module lcd_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= RST_VAL;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 controller: autonomous power-up/init sequence, then one byte per handshake
// with setup, enable-pulse, hold and timer-based execution wait.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 12,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lcd_if.slave       bus,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  localparam int T_MAX = max_int(max_int(max_int(T_POWERUP, T_SETUP), max_int(T_PULSE, T_HOLD)),
                                 max_int(T_EXEC, T_CLEAR));
  localparam int TW = $clog2(T_MAX) + 1;

  if (T_POWERUP < 1 || T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_EXEC < 1 || T_CLEAR < 1)
  begin : g_bad_timing
    $error("lcd_ctrl: every timing parameter must be at least 1");
  end

  lcd_state_e  r_state;
  logic [1:0]  r_idx;
  logic        r_ready;
  logic        r_init_done;
  logic        r_on;
  logic        r_en;
  logic        r_rs;
  logic [7:0]  r_data;

  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_zero;
  logic          w_accept;
  logic          w_slow;

  assign w_accept = bus.cmd_valid && r_ready;
  assign w_slow   = is_slow_cmd(r_rs, r_data);

  lcd_timer #(
    .W       (TW),
    .RST_VAL (TW'(T_POWERUP - 1))
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .zero_o     (w_zero)
  );

  // Timer reload on entry to each timed state; PWRUP is covered by the reset value.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      LOAD: begin
        w_load     = 1'b1;
        w_load_val = TW'(T_SETUP - 1);
      end
      SETUP: begin
        w_load     = w_zero;
        w_load_val = TW'(T_PULSE - 1);
      end
      PULSE: begin
        w_load     = w_zero;
        w_load_val = TW'(T_HOLD - 1);
      end
      HOLD: begin
        w_load     = w_zero;
        w_load_val = w_slow ? TW'(T_CLEAR - 1) : TW'(T_EXEC - 1);
      end
      IDLE: begin
        w_load     = w_accept;
        w_load_val = TW'(T_SETUP - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= PWRUP;
      r_idx       <= 2'd0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_on        <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_on <= 1'b1;
      case (r_state)
        PWRUP: begin
          if (w_zero) r_state <= LOAD;
        end
        LOAD: begin
          r_rs    <= 1'b0;
          r_data  <= LCD_INIT_SEQ[r_idx];
          r_state <= SETUP;
        end
        SETUP: begin
          if (w_zero) begin
            r_en    <= 1'b1;
            r_state <= PULSE;
          end
        end
        PULSE: begin
          if (w_zero) begin
            r_en    <= 1'b0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_zero) r_state <= WAIT;
        end
        WAIT: begin
          if (w_zero) begin
            if (!r_init_done && r_idx != 2'd3) begin
              r_idx   <= r_idx + 2'd1;
              r_state <= LOAD;
            end else begin
              r_init_done <= 1'b1;
              r_ready     <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        IDLE: begin
          if (w_accept) begin
            r_rs    <= bus.cmd_rs;
            r_data  <= bus.cmd_data;
            r_ready <= 1'b0;
            r_state <= SETUP;
          end
        end
        default: r_state <= PWRUP;
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign init_done_o   = r_init_done;
  assign lcd_on_o      = r_on;
  assign lcd_en_o      = r_en;
  assign lcd_rs_o      = r_rs;
  assign lcd_rw_o      = 1'b0;
  assign lcd_data_o    = r_data;

endmodule
